// File: rtl/fft_ctrl_pkg.sv
// Shared types and helpers for the FFT controller and its address generator.
// Holds the sequencer state encoding and the stage-index width helper.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } ctrlState_t;

    // Bits needed to hold a stage index 0..log2(n)-1 (at least one bit).
    function automatic int stageWidth(input int n);
        int logN;
        logN = $clog2(n);
        return (logN > 1) ? $clog2(logN) : 1;
    endfunction

endpackage

// File: rtl/fft_dly_line.sv
// Fixed-depth shift register that carries the write-side {valid,stage,pair} tag.
// A synchronous clear empties every slot so nothing in flight survives a reset.
module fft_dly_line #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 3
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic [WIDTH-1:0] i_data,
    output logic [WIDTH-1:0] o_data
);

    logic [WIDTH-1:0] r_pipe [DEPTH];

    always_ff @(posedge i_clk) begin
        if (i_clr) begin
            for (int k = 0; k < DEPTH; k++) begin
                r_pipe[k] <= '0;
            end
        end else begin
            r_pipe[0] <= i_data;
            for (int k = 1; k < DEPTH; k++) begin
                r_pipe[k] <= r_pipe[k-1];
            end
        end
    end

    assign o_data = r_pipe[DEPTH-1];

endmodule

// File: rtl/fft_ctrl.sv
// Stage/pair sequencer for the in-place radix-2 FFT, with a matched write-back tag.
// Optional macro FFT_CTRL_CYCLE_CNT_EN adds the o_cycles busy-cycle counter.
module fft_ctrl
    import fft_ctrl_pkg::*;
#(
    parameter int N      = 8,
    parameter int I      = 4,
    parameter int F      = 4,
    parameter int RD_LAT = 1,
    parameter int BF_LAT = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_start,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_rd_en,
    output logic [stageWidth(N)-1:0] o_stage,
    output logic [$clog2(N)-1:0]     o_pair,
    output logic                     o_wr_en,
    output logic [stageWidth(N)-1:0] o_wr_stage,
    output logic [$clog2(N)-1:0]     o_wr_pair
`ifdef FFT_CTRL_CYCLE_CNT_EN
    ,
    output logic [15:0]              o_cycles
`endif
);

    localparam int LOGN = $clog2(N);
    localparam int STW  = stageWidth(N);
    localparam int PW   = LOGN;
    localparam int D    = RD_LAT + BF_LAT;
    localparam int DCW  = $clog2(D + 1);
    localparam int DLW  = 1 + STW + PW;

    localparam logic [PW-1:0]  LAST_PAIR  = PW'(N / 2 - 1);
    localparam logic [STW-1:0] LAST_STAGE = STW'(LOGN - 1);
    localparam logic [DCW-1:0] LAST_DRAIN = DCW'(D - 1);

    // Sample widths only matter to the datapath; they are checked here for sanity.
    if (N < 4 || (N & (N - 1)) != 0 || RD_LAT < 1 || BF_LAT < 0 || (I + F) < 1) begin : g_badParams
        $error("fft_ctrl: illegal parameter set");
    end

    ctrlState_t       r_state;
    logic             r_busy;
    logic             r_done;
    logic             r_rdEn;
    logic [STW-1:0]   r_stage;
    logic [PW-1:0]    r_pair;
    logic [DCW-1:0]   r_drainCnt;
    logic [DLW-1:0]   w_dlyIn;
    logic [DLW-1:0]   w_dlyOut;

    // DRAIN lasts exactly D cycles so the last write lands just before the next stage reads.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_rdEn     <= 1'b0;
            r_stage    <= '0;
            r_pair     <= '0;
            r_drainCnt <= '0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (i_start) begin
                        r_state <= ISSUE;
                        r_busy  <= 1'b1;
                        r_rdEn  <= 1'b1;
                        r_stage <= '0;
                        r_pair  <= '0;
                    end
                end
                ISSUE: begin
                    if (r_pair == LAST_PAIR) begin
                        r_state    <= DRAIN;
                        r_rdEn     <= 1'b0;
                        r_drainCnt <= '0;
                    end else begin
                        r_pair <= r_pair + PW'(1);
                    end
                end
                DRAIN: begin
                    if (r_drainCnt == LAST_DRAIN) begin
                        if (r_stage == LAST_STAGE) begin
                            r_state <= DONE;
                            r_done  <= 1'b1;
                        end else begin
                            r_state <= ISSUE;
                            r_rdEn  <= 1'b1;
                            r_stage <= r_stage + STW'(1);
                            r_pair  <= '0;
                        end
                    end else begin
                        r_drainCnt <= r_drainCnt + DCW'(1);
                    end
                end
                DONE: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                end
                default: begin
                    r_state <= IDLE;
                    r_busy  <= 1'b0;
                    r_rdEn  <= 1'b0;
                end
            endcase
        end
    end

    assign w_dlyIn = {r_rdEn, r_stage, r_pair};

    fft_dly_line #(
        .WIDTH (DLW),
        .DEPTH (D)
    ) u_wrDly (
        .i_clk  (i_clk),
        .i_clr  (i_rst),
        .i_data (w_dlyIn),
        .o_data (w_dlyOut)
    );

    assign o_busy  = r_busy;
    assign o_done  = r_done;
    assign o_rd_en = r_rdEn;
    assign o_stage = r_stage;
    assign o_pair  = r_pair;
    assign {o_wr_en, o_wr_stage, o_wr_pair} = w_dlyOut;

`ifdef FFT_CTRL_CYCLE_CNT_EN
    logic [15:0] r_cycles;

    // Counts busy cycles of the current transform and keeps the total once idle.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cycles <= '0;
        end else if (r_state == IDLE && i_start) begin
            r_cycles <= '0;
        end else if (r_busy && r_cycles != 16'hFFFF) begin
            r_cycles <= r_cycles + 16'd1;
        end
    end

    assign o_cycles = r_cycles;
`endif

endmodule

// File: tb/tb_fft_ctrl.sv
// Self-checking bench for fft_ctrl: an N=8/D=3 and an N=16/D=1 instance driven by
// cycle tables built from closed-form timing, plus a write-back scoreboard.
module tb_fft_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst8 = 1'b1, start8 = 1'b0;
    logic rst16 = 1'b1, start16 = 1'b0;

    logic       busy8, done8, rdEn8, wrEn8;
    logic [1:0] stage8, wrStage8;
    logic [2:0] pair8, wrPair8;
    logic       busy16, done16, rdEn16, wrEn16;
    logic [1:0] stage16, wrStage16;
    logic [3:0] pair16, wrPair16;
`ifdef FFT_CTRL_CYCLE_CNT_EN
    logic [15:0] cycles8, cycles16;
`endif

    fft_ctrl #(.N(8), .I(4), .F(4), .RD_LAT(1), .BF_LAT(2)) dut8 (
        .i_clk      (clk),
        .i_rst      (rst8),
        .i_start    (start8),
        .o_busy     (busy8),
        .o_done     (done8),
        .o_rd_en    (rdEn8),
        .o_stage    (stage8),
        .o_pair     (pair8),
        .o_wr_en    (wrEn8),
        .o_wr_stage (wrStage8),
        .o_wr_pair  (wrPair8)
`ifdef FFT_CTRL_CYCLE_CNT_EN
        ,
        .o_cycles   (cycles8)
`endif
    );

    fft_ctrl #(.N(16), .I(4), .F(4), .RD_LAT(1), .BF_LAT(0)) dut16 (
        .i_clk      (clk),
        .i_rst      (rst16),
        .i_start    (start16),
        .o_busy     (busy16),
        .o_done     (done16),
        .o_rd_en    (rdEn16),
        .o_stage    (stage16),
        .o_pair     (pair16),
        .o_wr_en    (wrEn16),
        .o_wr_stage (wrStage16),
        .o_wr_pair  (wrPair16)
`ifdef FFT_CTRL_CYCLE_CNT_EN
        ,
        .o_cycles   (cycles16)
`endif
    );

    typedef struct {
        logic chk;
        logic rst;
        logic start;
        logic busy;
        logic done;
        logic rdEn;
        int   stage;
        int   pair;
        logic wrEn;
        int   cycles;
    } vec_t;

    typedef struct {
        int cyc;
        int stage;
        int pair;
    } wr_t;

    vec_t vecs[$];
    vec_t expQ[$];
    wr_t  wrQ[$];
    int   nTests = 0;
    int   nFail  = 0;
    int   cyc    = 0;

    // Expected outputs in cycle t of a transform whose start was sampled in cycle 0.
    function automatic vec_t modelVec(input int t, input int n, input int d,
                                      input logic start, input logic rst);
        vec_t v;
        int logN, half, per, last, tw;
        logN = $clog2(n);
        half = n / 2;
        per  = half + d;
        last = logN * per + 1;
        v = '{chk: 1'b1, rst: rst, start: start, busy: 1'b0, done: 1'b0, rdEn: 1'b0,
              stage: 0, pair: 0, wrEn: 1'b0, cycles: 0};
        if (t >= 1 && t < last) begin
            v.busy  = 1'b1;
            v.stage = (t - 1) / per;
            v.rdEn  = ((t - 1) % per) < half;
            v.pair  = v.rdEn ? (t - 1) % per : half - 1;
        end else if (t >= last) begin
            v.busy  = (t == last);
            v.done  = (t == last);
            v.stage = logN - 1;
            v.pair  = half - 1;
        end
        tw = t - d;
        if (tw >= 1 && tw < last && ((tw - 1) % per) < half) v.wrEn = 1'b1;
        v.cycles = (t <= 1) ? 0 : ((t - 1 < last) ? t - 1 : last);
        return v;
    endfunction

    function automatic vec_t resetVec();
        vec_t v;
        v = modelVec(0, 8, 3, 1'b0, 1'b1);
        v.chk = 1'b0;
        return v;
    endfunction

    task automatic checkVal(input string name, input int act, input int exp);
        nTests++;
        if (act != exp) begin
            nFail++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    task automatic pushWrites(input int c, input int n, input int d);
        int half, per;
        half = n / 2;
        per  = half + d;
        for (int s = 0; s < $clog2(n); s++) begin
            for (int p = 0; p < half; p++) begin
                wrQ.push_back('{cyc: c + 1 + s * per + p + d, stage: s, pair: p});
            end
        end
    endtask

    task automatic applyStimulus(input int which, input vec_t v);
        @(posedge clk);
        #1;
        cyc++;
        if (which == 8) begin
            rst8 = v.rst;  start8 = v.start;  rst16 = 1'b1; start16 = 1'b0;
        end else begin
            rst16 = v.rst; start16 = v.start; rst8 = 1'b1;  start8 = 1'b0;
        end
        expQ.push_back(v);
        if (v.start && !v.rst && !v.busy) pushWrites(cyc, which, (which == 8) ? 3 : 1);
    endtask

    task automatic checkOutput(input int which);
        vec_t v;
        wr_t  w;
        int aBusy, aDone, aRd, aStage, aPair, aWr, aWrStage, aWrPair, aCyc;
        @(negedge clk);
        v = expQ.pop_front();
        aCyc = 0;
        if (which == 8) begin
            aBusy = busy8; aDone = done8; aRd = rdEn8; aStage = stage8; aPair = pair8;
            aWr = wrEn8; aWrStage = wrStage8; aWrPair = wrPair8;
`ifdef FFT_CTRL_CYCLE_CNT_EN
            aCyc = cycles8;
`endif
        end else begin
            aBusy = busy16; aDone = done16; aRd = rdEn16; aStage = stage16; aPair = pair16;
            aWr = wrEn16; aWrStage = wrStage16; aWrPair = wrPair16;
`ifdef FFT_CTRL_CYCLE_CNT_EN
            aCyc = cycles16;
`endif
        end
        if (v.chk) begin
            checkVal($sformatf("n%0d c%0d busy", which, cyc), aBusy, v.busy);
            checkVal($sformatf("n%0d c%0d done", which, cyc), aDone, v.done);
            checkVal($sformatf("n%0d c%0d rd_en", which, cyc), aRd, v.rdEn);
            checkVal($sformatf("n%0d c%0d stage", which, cyc), aStage, v.stage);
            checkVal($sformatf("n%0d c%0d pair", which, cyc), aPair, v.pair);
            checkVal($sformatf("n%0d c%0d wr_en", which, cyc), aWr, v.wrEn);
`ifdef FFT_CTRL_CYCLE_CNT_EN
            checkVal($sformatf("n%0d c%0d cycles", which, cyc), aCyc, v.cycles);
`endif
            if (aRd != 0 && aWr != 0)
                checkVal($sformatf("n%0d c%0d rd/wr stage overlap", which, cyc), aWrStage, aStage);
        end
        if (aWr != 0) begin
            if (wrQ.size() == 0) begin
                checkVal($sformatf("n%0d c%0d unexpected write", which, cyc), aWr, 0);
            end else begin
                w = wrQ.pop_front();
                checkVal($sformatf("n%0d write cycle", which), cyc, w.cyc);
                checkVal($sformatf("n%0d c%0d wr_stage", which, cyc), aWrStage, w.stage);
                checkVal($sformatf("n%0d c%0d wr_pair", which, cyc), aWrPair, w.pair);
            end
        end
        if (v.rst) wrQ.delete();
    endtask

    task automatic runScenario(input int which, input string name);
        $display("[TB] scenario %s on N=%0d", name, which);
        cyc = -2;
        foreach (vecs[k]) begin
            applyStimulus(which, vecs[k]);
            checkOutput(which);
        end
        checkVal({name, " pending writes"}, wrQ.size(), 0);
        wrQ.delete();
    endtask

    initial begin
        // Single start pulse: read/write windows, done pulse and cycle count.
        vecs.delete();
        vecs.push_back(resetVec());
        for (int t = 0; t <= 24; t++) vecs.push_back(modelVec(t, 8, 3, t == 0, 1'b0));
        runScenario(8, "single");

        // Start held high: exactly one transform, then a restart from IDLE.
        vecs.delete();
        vecs.push_back(resetVec());
        for (int t = 0; t <= 48; t++) begin
            if (t <= 23) vecs.push_back(modelVec(t, 8, 3, 1'b1, 1'b0));
            else         vecs.push_back(modelVec(t - 23, 8, 3, t <= 45, 1'b0));
        end
        runScenario(8, "heldStart");

        // Reset in cycle 10 aborts the transform and drops in-flight writes.
        vecs.delete();
        vecs.push_back(resetVec());
        for (int t = 0; t <= 9; t++) vecs.push_back(modelVec(t, 8, 3, t == 0, 1'b0));
        vecs.push_back(modelVec(10, 8, 3, 1'b0, 1'b1));
        for (int t = 11; t <= 18; t++) vecs.push_back(modelVec(0, 8, 3, 1'b0, 1'b0));
        runScenario(8, "midReset");

        // N=16 with a one-cycle pipeline: four stages of nine cycles.
        vecs.delete();
        vecs.push_back(resetVec());
        for (int t = 0; t <= 40; t++) vecs.push_back(modelVec(t, 16, 1, t == 0, 1'b0));
        runScenario(16, "n16");

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule
